// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU writeback (A, never stalls)
// and load writeback (B, handshaked through a small FIFO), with a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int WIDTH        = 24,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  input  logic [ADDRESSWIDTH-1:0]   a_addr,
  input  logic [WIDTH-1:0]          a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [ADDRESSWIDTH-1:0]   b_addr,
  input  logic [WIDTH-1:0]          b_data,
  input  logic [ADDRESSWIDTH-1:0]   chk_addr1,
  input  logic [ADDRESSWIDTH-1:0]   chk_addr2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic                      we3,
  output logic [ADDRESSWIDTH-1:0]   wa3,
  output logic [WIDTH-1:0]          wd3,
  output logic                      pc_drop,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]           DEPTH_C = CW'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(REGNUM - 1);

  logic [ADDRESSWIDTH-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0]        r_data [DEPTH];
  logic [DEPTH-1:0]        r_live;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW-1:0]           r_wr_ptr;
  logic [CW-1:0]           r_count;

  logic                    r_we3_p1;
  logic [ADDRESSWIDTH-1:0] r_wa3_p1;
  logic [WIDTH-1:0]        r_wd3_p1;
  logic                    r_pc_drop_p1;

  logic                    w_b_xfer;
  logic                    w_a_issue;
  logic                    w_b_real;
  logic                    w_issue;
  logic                    w_pop;
  logic                    w_bypass;
  logic                    w_push;
  logic [ADDRESSWIDTH-1:0] w_iss_addr;
  logic [WIDTH-1:0]        w_iss_data;
  logic                    w_hit1;
  logic                    w_hit2;

  assign b_ready   = !reset && (r_count < DEPTH_C);
  assign w_b_xfer  = b_valid && b_ready;
  assign w_a_issue = a_valid && (a_addr != PC_ADDR);
  assign w_b_real  = w_b_xfer && (b_addr != PC_ADDR);

  // A wins outright; otherwise the FIFO head (live or dead) leaves; bypass only when empty.
  always_comb begin
    w_issue    = 1'b0;
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    w_iss_addr = a_addr;
    w_iss_data = a_data;
    if (w_a_issue) begin
      w_issue = 1'b1;
    end else if (r_count != '0) begin
      w_pop = 1'b1;
      if (r_live[r_rd_ptr]) begin
        w_issue    = 1'b1;
        w_iss_addr = r_addr[r_rd_ptr];
        w_iss_data = r_data[r_rd_ptr];
      end
    end else if (w_b_real) begin
      w_issue    = 1'b1;
      w_bypass   = 1'b1;
      w_iss_addr = b_addr;
      w_iss_data = b_data;
    end
  end

  // A same-cycle B write to the address A is writing is older, so it is simply dropped.
  assign w_push = w_b_real && !w_bypass && !(w_a_issue && (a_addr == b_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_live       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_we3_p1     <= 1'b0;
      r_wa3_p1     <= '0;
      r_wd3_p1     <= '0;
      r_pc_drop_p1 <= 1'b0;
    end else begin
      r_we3_p1     <= w_issue;
      r_pc_drop_p1 <= (a_valid && (a_addr == PC_ADDR)) || (w_b_xfer && (b_addr == PC_ADDR));
      if (w_issue) begin
        r_wa3_p1 <= w_iss_addr;
        r_wd3_p1 <= w_iss_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_a_issue && r_live[i] && (r_addr[i] == a_addr)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_live[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= b_addr;
      r_data[r_wr_ptr] <= b_data;
    end
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1 = w_hit1 | (r_live[i] && (r_addr[i] == chk_addr1));
      w_hit2 = w_hit2 | (r_live[i] && (r_addr[i] == chk_addr2));
    end
    w_hit1 = w_hit1 | (r_we3_p1 && (r_wa3_p1 == chk_addr1))
                    | (w_a_issue && (a_addr == chk_addr1))
                    | (w_b_real && (b_addr == chk_addr1));
    w_hit2 = w_hit2 | (r_we3_p1 && (r_wa3_p1 == chk_addr2))
                    | (w_a_issue && (a_addr == chk_addr2))
                    | (w_b_real && (b_addr == chk_addr2));
  end

  assign hazard1    = !reset && (chk_addr1 != PC_ADDR) && w_hit1;
  assign hazard2    = !reset && (chk_addr2 != PC_ADDR) && w_hit2;
  assign we3        = r_we3_p1;
  assign wa3        = r_wa3_p1;
  assign wd3        = r_wd3_p1;
  assign pc_drop    = r_pc_drop_p1;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset;
  logic             a_valid;
  logic [AW-1:0]    a_addr;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_data;
  logic [AW-1:0]    chk_addr1;
  logic [AW-1:0]    chk_addr2;
  logic             hazard1;
  logic             hazard2;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic             pc_drop;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .REGNUM(16), .ADDRESSWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .pc_drop(pc_drop), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads as a queue of {addr, data, still-wanted}.
  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    bit               live;
  } ent_t;

  ent_t             q[$];
  bit               m_init = 1'b0;
  logic             m_we3;
  logic [AW-1:0]    m_wa3;
  logic [WIDTH-1:0] m_wd3;
  logic             m_pcd;

  function automatic bit m_ready();
    return !reset && (q.size() < DEPTH);
  endfunction

  function automatic bit m_hazard(input logic [AW-1:0] c);
    if (reset || c == 4'd15) return 1'b0;
    if (m_we3 && m_wa3 == c) return 1'b1;
    foreach (q[i]) if (q[i].live && q[i].addr == c) return 1'b1;
    if (a_valid && a_addr == c) return 1'b1;
    if (b_valid && m_ready() && b_addr == c) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_we3  = 1'b0;
      m_wa3  = '0;
      m_wd3  = '0;
      m_pcd  = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      bit   bx, aiss, issued, bypassed;
      ent_t e;
      bx       = b_valid && (q.size() < DEPTH);
      aiss     = a_valid && a_addr != 4'd15;
      m_pcd    = (a_valid && a_addr == 4'd15) || (bx && b_addr == 4'd15);
      issued   = 1'b0;
      bypassed = 1'b0;
      if (aiss) begin
        issued = 1'b1; m_wa3 = a_addr; m_wd3 = a_data;
        foreach (q[i]) if (q[i].addr == a_addr) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.live) begin issued = 1'b1; m_wa3 = e.addr; m_wd3 = e.data; end
      end else if (bx && b_addr != 4'd15) begin
        issued = 1'b1; bypassed = 1'b1; m_wa3 = b_addr; m_wd3 = b_data;
      end
      if (bx && b_addr != 4'd15 && !bypassed && !(aiss && a_addr == b_addr)) begin
        e.addr = b_addr; e.data = b_data; e.live = 1'b1;
        q.push_back(e);
      end
      m_we3 = issued;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_we3",     32'(we3),        32'(m_we3));
      chk("m_wa3",     32'(wa3),        32'(m_wa3));
      chk("m_wd3",     32'(wd3),        32'(m_wd3));
      chk("m_pc_drop", 32'(pc_drop),    32'(m_pcd));
      chk("m_count",   32'(fifo_count), 32'(q.size()));
      chk("m_b_ready", 32'(b_ready),    32'(m_ready()));
      chk("m_hazard1", 32'(hazard1),    32'(m_hazard(chk_addr1)));
      chk("m_hazard2", 32'(hazard2),    32'(m_hazard(chk_addr2)));
    end
  end

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [WIDTH-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 24'h0, 1'b0, 4'd0, 24'h0);
  endtask

  initial begin
    reset = 1'b1; chk_addr1 = 4'd0; chk_addr2 = 4'd0;
    idle();
    tick(); tick();
    #1;
    chk("rst_b_ready", 32'(b_ready), 32'h0);
    chk("rst_we3",     32'(we3),     32'h0);
    chk("rst_count",   32'(fifo_count), 32'h0);
    chk("rst_wd3",     32'(wd3),     32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_b_ready", 32'(b_ready), 32'h1);

    // A only
    tick();
    drive(1'b1, 4'd3, 24'h00ABCD, 1'b0, 4'd0, 24'h0);
    chk_addr1 = 4'd3;
    #1;
    chk("a_hazard1", 32'(hazard1), 32'h1);
    tick();
    chk("a_we3", 32'(we3), 32'h1);
    chk("a_wa3", 32'(wa3), 32'h3);
    chk("a_wd3", 32'(wd3), 32'h00ABCD);
    idle();
    tick();
    chk("a_we3_off", 32'(we3), 32'h0);
    chk("a_wa3_hold", 32'(wa3), 32'h3);

    // Bypass
    drive(1'b0, 4'd0, 24'h0, 1'b1, 4'd5, 24'h000111);
    tick();
    chk("byp_we3",   32'(we3), 32'h1);
    chk("byp_wa3",   32'(wa3), 32'h5);
    chk("byp_wd3",   32'(wd3), 32'h000111);
    chk("byp_count", 32'(fifo_count), 32'h0);
    idle();
    tick();

    // Collision and fill
    drive(1'b1, 4'd1, 24'h000101, 1'b1, 4'd6, 24'h000666);
    tick();
    chk("fill_wa3_a", 32'(wa3), 32'h1);
    chk("fill_count1", 32'(fifo_count), 32'h1);
    drive(1'b1, 4'd1, 24'h000102, 1'b1, 4'd7, 24'h000777);
    tick();
    chk("fill_count2", 32'(fifo_count), 32'h2);
    chk("fill_b_ready", 32'(b_ready), 32'h0);
    drive(1'b1, 4'd1, 24'h000103, 1'b0, 4'd0, 24'h0);
    tick();
    drive(1'b1, 4'd1, 24'h000104, 1'b0, 4'd0, 24'h0);
    tick();
    chk("fill_wd3_a4", 32'(wd3), 32'h000104);
    idle();
    tick();
    chk("drain_wa3_6", 32'(wa3), 32'h6);
    chk("drain_wd3_6", 32'(wd3), 32'h000666);
    tick();
    chk("drain_we3_7", 32'(we3), 32'h1);
    chk("drain_wa3_7", 32'(wa3), 32'h7);
    chk("drain_wd3_7", 32'(wd3), 32'h000777);
    tick();
    chk("drain_done", 32'(we3), 32'h0);
    chk("drain_count", 32'(fifo_count), 32'h0);

    // Ordering squash
    drive(1'b1, 4'd2, 24'h000222, 1'b1, 4'd4, 24'h000444);
    tick();
    chk("sq_count", 32'(fifo_count), 32'h1);
    drive(1'b1, 4'd4, 24'h000AAA, 1'b0, 4'd0, 24'h0);
    chk_addr1 = 4'd4;
    tick();
    chk("sq_wa3", 32'(wa3), 32'h4);
    chk("sq_wd3", 32'(wd3), 32'h000AAA);
    chk("sq_count_dead", 32'(fifo_count), 32'h1);
    idle();
    #1;
    chk("sq_hazard1", 32'(hazard1), 32'h1);
    tick();
    chk("sq_dead_pop_we3", 32'(we3), 32'h0);
    chk("sq_dead_pop_cnt", 32'(fifo_count), 32'h0);
    chk("sq_wd3_hold", 32'(wd3), 32'h000AAA);
    #1;
    chk("sq_hazard1_clr", 32'(hazard1), 32'h0);
    tick();
    chk("sq_no_late_we3", 32'(we3), 32'h0);

    // PC drop
    chk_addr1 = 4'd15; chk_addr2 = 4'd15;
    drive(1'b0, 4'd0, 24'h0, 1'b1, 4'd15, 24'h000FFF);
    #1;
    chk("pc_hazard1", 32'(hazard1), 32'h0);
    chk("pc_hazard2", 32'(hazard2), 32'h0);
    tick();
    chk("pc_we3",   32'(we3), 32'h0);
    chk("pc_drop",  32'(pc_drop), 32'h1);
    chk("pc_count", 32'(fifo_count), 32'h0);
    drive(1'b1, 4'd15, 24'h000EEE, 1'b0, 4'd0, 24'h0);
    tick();
    chk("pc_a_we3",  32'(we3), 32'h0);
    chk("pc_a_drop", 32'(pc_drop), 32'h1);
    idle();
    tick();
    chk("pc_drop_off", 32'(pc_drop), 32'h0);

    // Hazard and reset
    chk_addr1 = 4'd0; chk_addr2 = 4'd0;
    drive(1'b1, 4'd2, 24'h000202, 1'b1, 4'd9, 24'h000999);
    tick();
    idle();
    chk_addr1 = 4'd9;
    #1;
    chk("hz_hazard1", 32'(hazard1), 32'h1);
    reset = 1'b1;
    #1;
    chk("hz_rst_hazard1", 32'(hazard1), 32'h0);
    chk("hz_rst_b_ready", 32'(b_ready), 32'h0);
    tick();
    chk("hz_rst_count", 32'(fifo_count), 32'h0);
    chk("hz_rst_we3",   32'(we3), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hz_no_write9", 32'(we3), 32'h0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between two writeback sources.
  - Port A: ALU writeback. Never stalls, highest priority.
  - Port B: memory-load writeback. Valid/ready handshake, DEPTH-entry FIFO.
- Drives the register file write port from a registered output stage.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on its two read addresses.
- Sits between the execute/memory writeback paths and the register file.

Parameters:
- WIDTH, 24, data width of each register
- REGNUM, 16, number of register addresses
- ADDRESSWIDTH, 4, width of register addresses
- DEPTH, 2, port-B FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  ALU writeback request this cycle
- a_addr  in  ADDRESSWIDTH  ALU destination register
- a_data  in  WIDTH  ALU result
- b_valid  in  1  load writeback request
- b_ready  out  1  FIFO can accept a B request this cycle
- b_addr  in  ADDRESSWIDTH  load destination register
- b_data  in  WIDTH  load data
- chk_addr1  in  ADDRESSWIDTH  decode read address 1
- chk_addr2  in  ADDRESSWIDTH  decode read address 2
- hazard1  out  1  write pending to chk_addr1
- hazard2  out  1  write pending to chk_addr2
- we3  out  1  register file write enable (registered)
- wa3  out  ADDRESSWIDTH  register file write address (registered)
- wd3  out  WIDTH  register file write data (registered)
- pc_drop  out  1  one-cycle pulse: a request targeting address 15 was discarded
- fifo_count  out  clog2(DEPTH)+1  live B FIFO occupancy

Behaviour:
- Reset
  - Applies at the clk edge while reset=1.
  - Clears: FIFO (count 0, all entries invalid), we3=0, wa3=0, wd3=0, pc_drop=0.
  - While reset=1: b_ready=0 and hazard1/hazard2=0.
  - Reset mid-operation discards all queued and in-flight writes; none reach the register file.
- Handshake
  - B transfer occurs when b_valid & b_ready at a clk edge.
  - b_ready = !reset & (fifo_count < DEPTH). Combinational from state only, not from b_valid or a_valid.
- Address 15 (PC alias on the read ports) is never written.
  - A or B requests with addr=15 are accepted, then discarded: no FIFO entry, no we3.
  - pc_drop=1 the following cycle.
- Issue selection, once per cycle, evaluated in priority order:
  1. a_valid & a_addr!=15 -> issue A.
  2. Otherwise, FIFO head valid -> issue head and pop it.
  3. Otherwise, FIFO empty and B transfer with b_addr!=15 -> issue B directly (bypass); nothing is enqueued.
  4. Otherwise, no issue.
- Any B transfer not bypassed and not addr 15 is pushed at the tail.
  - Push and pop in the same cycle are allowed; count stays unchanged.
- Issued request is registered into we3/wa3/wd3 at the clk edge. Latency from request to register-file write is 1 cycle (the register file writes at the following edge).
  - No issue in a cycle -> we3=0 next cycle. wa3/wd3 hold their previous values.
- Ordering rule: B data is architecturally older than a same-cycle or later A write.
  - When A issues to address X, every valid FIFO entry with addr X is invalidated.
  - Invalidated entries are popped without issuing, at 1 entry/cycle when they reach the head.
  - A B request transferred in the same cycle as an A issue to the same address is accepted and dropped: not enqueued, not written.
- Invalidated-entry timing
  - Invalidated entries still occupy the FIFO and count toward fifo_count until popped.
  - A dead head is popped in a cycle with no A issue. In that cycle the next valid entry does not issue.
- Scoreboard
  - hazardN = 1 when chk_addrN matches any of:
    - wa3 while we3=1;
    - a valid FIFO entry;
    - a_addr while a_valid=1;
    - b_addr during a B transfer.
  - Address-15 requests never set a hazard.
  - Combinational.
- Widths
  - Data passes unmodified.
  - Addresses are compared over the full ADDRESSWIDTH.

Test Plan:
- Reset, then A only: a_valid=1, a_addr=3, a_data=24'h00ABCD -> next cycle we3=1, wa3=3, wd3=00ABCD; following cycle we3=0.
- Bypass: FIFO empty, A idle, B transfer addr=5, data=24'h000111 -> next cycle we3=1, wa3=5; fifo_count stays 0.
- Collision and fill: A streams addr=1 for 4 cycles while B sends addr=6, then addr=7.
  - fifo_count reaches 2 and b_ready=0.
  - After A stops, wa3=6 then wa3=7 on consecutive cycles.
- Ordering squash: FIFO holds B to addr=4, then A issues addr=4, data=24'h000AAA.
  - Only one write to 4 occurs (data 000AAA).
  - The dead entry pops without we3.
- PC drop: B transfer with b_addr=15 -> no we3, pc_drop=1 for one cycle, fifo_count unchanged, hazard never raised for chk_addr=15.
- Hazard and reset: FIFO holds addr=9 and chk_addr1=9 -> hazard1=1.
  - Assert reset for one cycle -> hazard1=0, fifo_count=0, we3=0.
  - The queued write to 9 never occurs.
